// File: rtl/hazard_tracker_if.sv
// Bypass-producer bundle between ID decode, data memory and the hazard tracker.
// Master drives decode/memory status; slave returns stall, freeze and slot exports.
interface hazard_tracker_if #(
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16
);
    logic                  forwarding_enable;
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_src1;
    logic [REG_ADDR_W-1:0] id_src2;
    logic                  id_two_src;
    logic [REG_ADDR_W-1:0] id_dest;
    logic                  id_wb_en;
    logic                  id_mem_read;
    logic                  id_mem_write;
    logic                  branch_taken;
    logic                  mem_ready;
    logic                  hazard;
    logic                  freeze;
    logic [REG_ADDR_W-1:0] mem_dest;
    logic                  mem_wb_en;
    logic [REG_ADDR_W-1:0] wb_dest;
    logic                  wb_wb_en;
    logic [CNT_W-1:0]      stall_count;

    modport master (
        output forwarding_enable, id_valid, id_src1, id_src2,
        output id_two_src, id_dest, id_wb_en, id_mem_read,
        output id_mem_write, branch_taken, mem_ready,
        input  hazard, freeze, mem_dest, mem_wb_en,
        input  wb_dest, wb_wb_en, stall_count
    );

    modport slave (
        input  forwarding_enable, id_valid, id_src1, id_src2,
        input  id_two_src, id_dest, id_wb_en, id_mem_read,
        input  id_mem_write, branch_taken, mem_ready,
        output hazard, freeze, mem_dest, mem_wb_en,
        output wb_dest, wb_wb_en, stall_count
    );
endinterface

// File: rtl/hazard_tracker.sv
// EXE/MEM/WB write tracker: load-use / no-bypass stall and memory-wait freeze.
// Optional stall-cycle counter enabled by `define HAZARD_STALL_COUNTER_EN.
module hazard_tracker #(
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16
) (
    input logic             clk,
    input logic             rst_n,
    hazard_tracker_if.slave bus
);
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dest;
        logic                  wb_en;
        logic                  mem_read;
        logic                  mem_write;
    } slot_t;

    slot_t exe_q, mem_q, wb_q;
    slot_t id_slot;
    logic  match_exe, match_mem;
    logic  id_live, hazard_c, freeze_c;

    always_comb begin
        match_exe = exe_q.valid & exe_q.wb_en &
                    ((exe_q.dest == bus.id_src1) |
                     (bus.id_two_src & (exe_q.dest == bus.id_src2)));
        match_mem = mem_q.valid & mem_q.wb_en &
                    ((mem_q.dest == bus.id_src1) |
                     (bus.id_two_src & (mem_q.dest == bus.id_src2)));
        id_live  = bus.id_valid & ~bus.branch_taken;
        hazard_c = 1'b0;
        if (id_live) begin
            if (bus.forwarding_enable)
                hazard_c = match_exe & exe_q.mem_read;
            else
                hazard_c = match_exe | match_mem;
        end
        freeze_c = mem_q.valid & (mem_q.mem_read | mem_q.mem_write)
                 & ~bus.mem_ready;
    end

    always_comb begin
        id_slot = '0;
        if (id_live && !hazard_c) begin
            id_slot.valid     = 1'b1;
            id_slot.dest      = bus.id_dest;
            id_slot.wb_en     = bus.id_wb_en;
            id_slot.mem_read  = bus.id_mem_read;
            id_slot.mem_write = bus.id_mem_write;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exe_q <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!freeze_c) begin
            wb_q  <= mem_q;
            mem_q <= exe_q;
            exe_q <= id_slot;
        end
    end

    assign bus.hazard    = hazard_c;
    assign bus.freeze    = freeze_c;
    assign bus.mem_dest  = mem_q.dest;
    assign bus.mem_wb_en = mem_q.valid & mem_q.wb_en;
    assign bus.wb_dest   = wb_q.dest;
    assign bus.wb_wb_en  = wb_q.valid & wb_q.wb_en;

`ifdef HAZARD_STALL_COUNTER_EN
    logic [CNT_W-1:0] stall_q;

    // saturates rather than wrapping so long stalls stay visible
    always_ff @(posedge clk) begin
        if (!rst_n)
            stall_q <= '0;
        else if ((hazard_c || freeze_c) && (stall_q != '1))
            stall_q <= stall_q + CNT_W'(1);
    end

    assign bus.stall_count = stall_q;
`else
    assign bus.stall_count = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_hazard_tracker.sv
// Directed bench for hazard_tracker: reset, load-use, no-bypass, memory wait,
// branch squash, and the stall counter (saturating copy with CNT_W=2).
module tb_hazard_tracker;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    hazard_tracker_if #(.REG_ADDR_W(4), .CNT_W(16)) bus ();
    hazard_tracker_if #(.REG_ADDR_W(4), .CNT_W(2))  bus_s ();

    assign bus_s.forwarding_enable = bus.forwarding_enable;
    assign bus_s.id_valid          = bus.id_valid;
    assign bus_s.id_src1           = bus.id_src1;
    assign bus_s.id_src2           = bus.id_src2;
    assign bus_s.id_two_src        = bus.id_two_src;
    assign bus_s.id_dest           = bus.id_dest;
    assign bus_s.id_wb_en          = bus.id_wb_en;
    assign bus_s.id_mem_read       = bus.id_mem_read;
    assign bus_s.id_mem_write      = bus.id_mem_write;
    assign bus_s.branch_taken      = bus.branch_taken;
    assign bus_s.mem_ready         = bus.mem_ready;

    hazard_tracker #(.REG_ADDR_W(4), .CNT_W(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    hazard_tracker #(.REG_ADDR_W(4), .CNT_W(2)) u_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s.slave)
    );

`ifdef HAZARD_STALL_COUNTER_EN
    localparam int CNT_MID  = 4;
    localparam int SAT_MID  = 3;
    localparam int CNT_END  = 6;
    localparam int SAT_END  = 3;
`else
    localparam int CNT_MID  = 0;
    localparam int SAT_MID  = 0;
    localparam int CNT_END  = 0;
    localparam int SAT_END  = 0;
`endif

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [3:0] s1,
                          input logic [3:0] s2, input logic two,
                          input logic [3:0] d, input logic wb,
                          input logic mr, input logic mw);
        bus.id_valid     = v;
        bus.id_src1      = s1;
        bus.id_src2      = s2;
        bus.id_two_src   = two;
        bus.id_dest      = d;
        bus.id_wb_en     = wb;
        bus.id_mem_read  = mr;
        bus.id_mem_write = mw;
        #1;
    endtask

    task automatic idle();
        set_id(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.forwarding_enable = 1'b1;
        bus.branch_taken = 1'b0;
        bus.mem_ready = 1'b0;
        set_id(1'b1, 4'd7, 4'd7, 1'b1, 4'd7, 1'b1, 1'b1, 1'b1);
        tick();
        tick();
        chk("rst_hazard", 32'(bus.hazard), 32'd0);
        chk("rst_freeze", 32'(bus.freeze), 32'd0);
        chk("rst_mem_wb_en", 32'(bus.mem_wb_en), 32'd0);
        chk("rst_wb_wb_en", 32'(bus.wb_wb_en), 32'd0);
        chk("rst_mem_dest", 32'(bus.mem_dest), 32'd0);
        chk("rst_wb_dest", 32'(bus.wb_dest), 32'd0);
        chk("rst_count", 32'(bus.stall_count), 32'd0);
        chk("rst_count_sat", 32'(bus_s.stall_count), 32'd0);
        bus.mem_ready = 1'b1;
        idle();
        rst_n = 1'b1;

        // load-use with forwarding on
        set_id(1'b1, 4'd0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 1'b0);
        chk("lu_pre_hazard", 32'(bus.hazard), 32'd0);
        tick();
        set_id(1'b1, 4'd3, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0);
        chk("lu_hazard", 32'(bus.hazard), 32'd1);
        tick();
        chk("lu_hazard_gone", 32'(bus.hazard), 32'd0);
        chk("lu_mem_dest", 32'(bus.mem_dest), 32'd3);
        chk("lu_mem_wb_en", 32'(bus.mem_wb_en), 32'd1);
        chk("lu_no_freeze", 32'(bus.freeze), 32'd0);
        tick();
        idle();
        chk("lu_wb_dest", 32'(bus.wb_dest), 32'd3);
        chk("lu_wb_wb_en", 32'(bus.wb_wb_en), 32'd1);
        chk("lu_mem_bubble", 32'(bus.mem_wb_en), 32'd0);
        tick();
        chk("lu_cons_dest", 32'(bus.mem_dest), 32'd4);
        chk("lu_cons_wb_en", 32'(bus.mem_wb_en), 32'd1);
        tick();
        tick();
        tick();

        // store waiting on memory, ADD R7 ahead of it in WB
        set_id(1'b1, 4'd0, 4'd0, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 4'd0, 4'd0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1);
        tick();
        idle();
        tick();
        bus.mem_ready = 1'b0;
        set_id(1'b1, 4'd0, 4'd0, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("mw_freeze", 32'(bus.freeze), 32'd1);
            chk("mw_wb_dest", 32'(bus.wb_dest), 32'd7);
            chk("mw_mem_dest", 32'(bus.mem_dest), 32'd2);
            chk("mw_mem_wb_en", 32'(bus.mem_wb_en), 32'd0);
            tick();
        end
        bus.mem_ready = 1'b1;
        #1;
        chk("mw_release", 32'(bus.freeze), 32'd0);
        chk("mw_wb_held", 32'(bus.wb_dest), 32'd7);
        chk("cnt_mid", 32'(bus.stall_count), 32'(CNT_MID));
        chk("cnt_mid_sat", 32'(bus_s.stall_count), 32'(SAT_MID));
        tick();
        idle();
        chk("mw_wb_store", 32'(bus.wb_dest), 32'd2);
        chk("mw_wb_store_en", 32'(bus.wb_wb_en), 32'd0);
        chk("mw_mem_bubble", 32'(bus.mem_wb_en), 32'd0);
        tick();
        chk("mw_next_dest", 32'(bus.mem_dest), 32'd8);
        chk("mw_next_wb_en", 32'(bus.mem_wb_en), 32'd1);
        tick();
        tick();
        tick();

        // forwarding off: ADD R5 then consumer reading R5 via src2
        bus.forwarding_enable = 1'b0;
        set_id(1'b1, 4'd0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 4'd1, 4'd5, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0);
        chk("nf_one_src", 32'(bus.hazard), 32'd0);
        set_id(1'b1, 4'd1, 4'd5, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0);
        chk("nf_exe_hazard", 32'(bus.hazard), 32'd1);
        tick();
        chk("nf_mem_hazard", 32'(bus.hazard), 32'd1);
        tick();
        chk("nf_wb_clear", 32'(bus.hazard), 32'd0);
        chk("nf_wb_dest", 32'(bus.wb_dest), 32'd5);
        tick();
        idle();
        tick();
        chk("nf_cons_dest", 32'(bus.mem_dest), 32'd6);
        chk("nf_cons_wb_en", 32'(bus.mem_wb_en), 32'd1);
        tick();
        tick();
        tick();

        // branch squash of a dependent load
        bus.forwarding_enable = 1'b1;
        set_id(1'b1, 4'd0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 4'd2, 4'd0, 1'b0, 4'd11, 1'b1, 1'b1, 1'b0);
        chk("br_dep_hazard", 32'(bus.hazard), 32'd1);
        bus.branch_taken = 1'b1;
        #1;
        chk("br_squash", 32'(bus.hazard), 32'd0);
        tick();
        bus.branch_taken = 1'b0;
        idle();
        chk("br_mem_dest", 32'(bus.mem_dest), 32'd2);
        chk("br_mem_wb_en", 32'(bus.mem_wb_en), 32'd1);
        tick();
        chk("br_bubble", 32'(bus.mem_wb_en), 32'd0);
        chk("br_wb_dest", 32'(bus.wb_dest), 32'd2);
        chk("cnt_end", 32'(bus.stall_count), 32'(CNT_END));
        chk("cnt_end_sat", 32'(bus_s.stall_count), 32'(SAT_END));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hazard_tracker.md
Name: hazard_tracker

Overview:
- Producer side of the operand-bypass interface.
- Tracks in-flight register writes through the EXE, MEM and WB slots and exports the MEM/WB destination and write-enable signals that the forwarding selector consumes.
- Decides when forwarding cannot resolve a dependency and asserts a stall, and freezes the whole pipeline while a data-memory access waits on the memory handshake.
- Sits between ID decode and the pipeline-register enables.

Parameters:
- REG_ADDR_W, 4, register-file address width.
- CNT_W, 16, stall-counter width (used only with the optional feature).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  synchronous active-low reset.
- forwarding_enable  input  1  1 = bypass paths active.
- id_valid  input  1  ID holds a real instruction.
- id_src1  input  REG_ADDR_W  first source register.
- id_src2  input  REG_ADDR_W  second source register.
- id_two_src  input  1  id_src2 is actually read.
- id_dest  input  REG_ADDR_W  destination register of ID instruction.
- id_wb_en  input  1  ID instruction writes a register.
- id_mem_read  input  1  ID instruction is a load.
- id_mem_write  input  1  ID instruction is a store.
- branch_taken  input  1  EXE resolved a taken branch; squash ID.
- mem_ready  input  1  data memory completes the access in MEM this cycle.
- hazard  output  1  stall IF/ID; bubble into EXE.
- freeze  output  1  hold all pipeline registers.
- mem_dest  output  REG_ADDR_W  MEM-slot destination.
- mem_wb_en  output  1  MEM-slot valid and writing.
- wb_dest  output  REG_ADDR_W  WB-slot destination.
- wb_wb_en  output  1  WB-slot valid and writing.
- stall_count  output  CNT_W  stall-cycle counter (optional feature only).

Behaviour:
- State: three slots, EXE, MEM and WB. Each slot holds valid, dest, wb_en, mem_read and mem_write.
- Reset (rst_n low at a rising edge): all slot fields cleared to 0. Combinational outputs then read 0: hazard=0, freeze=0, mem_wb_en=0, wb_wb_en=0, mem_dest=0, wb_dest=0. stall_count=0.
- Reset mid-freeze clears everything; no pending state survives.
- Exports are combinational from slot registers:
  - mem_dest = MEM.dest; mem_wb_en = MEM.valid & MEM.wb_en.
  - wb_dest = WB.dest; wb_wb_en = WB.valid & WB.wb_en.
- freeze (combinational) = MEM.valid & (MEM.mem_read | MEM.mem_write) & ~mem_ready.
- Match on slot S (combinational) = S.valid & S.wb_en & (S.dest==id_src1 | (id_two_src & S.dest==id_src2)).
- The WB slot never causes a hazard: the register file writes before it reads.
- hazard (combinational), qualified by id_valid & ~branch_taken:
  - forwarding_enable=0: match(EXE) | match(MEM).
  - forwarding_enable=1: match(EXE) & EXE.mem_read (load-use only).
- Slot update each rising edge, when freeze=0:
  - WB <= MEM.
  - MEM <= EXE.
  - EXE <= ID fields with valid = id_valid & ~hazard & ~branch_taken; otherwise a bubble (valid=0, other fields 0).
- When freeze=1, all slots hold.
  - hazard is still computed, but nothing advances.
  - branch_taken is ignored during freeze; upstream holds it until freeze drops.
- Latency: a load in EXE followed by a dependent ID instruction gives exactly 1 hazard cycle with forwarding on. With forwarding off it gives 2 hazard cycles (EXE match, then MEM match).
- Simultaneous events:
  - branch_taken with hazard: branch_taken wins; hazard=0; bubble enters EXE.
  - freeze with hazard: both high; freeze dominates; no slot moves.
  - mem_ready=1 in the first MEM cycle: no freeze (zero-wait memory).
- Slots with valid=0 never match, whatever their dest value.

Optional Feature:
- Macro: HAZARD_STALL_COUNTER_EN.
- Defined: stall_count increments by 1 on each rising edge where hazard=1 or freeze=1, saturating at all-ones. Cleared by reset.
- Not defined: stall_count is tied to 0 and no counter register exists.

Test Plan:
- Reset: rst_n=0 for 2 cycles with arbitrary inputs -> hazard=0, freeze=0, mem_wb_en=0, wb_wb_en=0, stall_count=0.
- Load-use, forwarding on: load R3 enters EXE; ID has src1=3, id_valid=1 -> hazard=1 for exactly 1 cycle. Next cycle the MEM slot has mem_dest=3, mem_wb_en=1, hazard=0.
- Forwarding off: ADD writes R5; next instruction has src2=5, id_two_src=1 -> hazard=1 for 2 cycles, then the consumer enters EXE. With id_two_src=0 -> hazard=0.
- Memory wait: store in MEM with mem_ready=0 for 3 cycles -> freeze=1 for 3 cycles; wb_dest and mem_dest stable; on mem_ready=1, freeze=0 and the slots advance next edge.
- Branch squash: branch_taken=1 while ID has load R2 with a matching dependency -> hazard=0; EXE holds a bubble next cycle; mem_wb_en=0 two cycles later.
- Counter (macro defined): 1 load-use stall plus 3 freeze cycles -> stall_count=4. With CNT_W=2 the same sequence -> stall_count saturates at 3.
